// File: rtl/bp_pkg.sv
// Shared encodings and PC slicing helpers for the BTB/PHT branch predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e PHT_RESET = WNT;

  // Both helpers return a 32-bit value; callers truncate to the table width.
  function automatic logic [31:0] bidx_of(input logic [31:0] pc, input int unsigned idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc, input int unsigned idx_bits);
    return pc >> (idx_bits + 2);
  endfunction

endpackage

// File: rtl/sat_counter2_update.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2_update
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Next-PC unit: tagged BTB plus 2-bit PHT (bimodal or gshare) prediction in IF,
// control-flow resolution and flush in EX, table training at the clock edge.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int  ENTRIES  = 32,
  parameter int  GHR_BITS = 5,
  parameter int  MODE     = 0,
  localparam int IDX      = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     current_pc,
  input  logic [31:0]     IF_ID_pc,
  input  logic [31:0]     ID_EX_pc,
  input  logic [31:0]     ID_EX_imm,
  input  logic [31:0]     EX_alu_result,
  input  logic            ID_EX_is_branch,
  input  logic            ID_EX_is_jal,
  input  logic            ID_EX_is_jalr,
  input  logic            EX_alu_bcond,
  input  logic [IDX-1:0]  ID_EX_pred_idx,
  output logic [IDX-1:0]  pred_idx,
  output logic [31:0]     next_pc,
  output logic            is_flush,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_flushes
);

  localparam int TAGW = 30 - IDX;

  logic                r_valid  [ENTRIES];
  logic [TAGW-1:0]     r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic                r_uncond [ENTRIES];
  logic [1:0]          r_pht    [ENTRIES];
  logic [GHR_BITS-1:0] r_ghr;
  logic [31:0]         r_perf_br;
  logic [31:0]         r_perf_fl;

  logic [IDX-1:0]      w_fetch_bidx;
  logic [TAGW-1:0]     w_fetch_tag;
  logic [IDX-1:0]      w_ghr_ext;
  logic [IDX-1:0]      w_pred_idx;
  logic                w_hit;
  logic                w_pred_taken;
  logic [31:0]         w_pred_next;

  logic                w_ctrl;
  logic                w_act_taken;
  logic [31:0]         w_act_target;
  logic [31:0]         w_correct;
  logic                w_flush;
  logic [IDX-1:0]      w_ex_bidx;
  logic [TAGW-1:0]     w_ex_tag;
  logic [1:0]          w_pht_next;
  logic [GHR_BITS-1:0] w_ghr_next;

  // Fetch-side lookup reads pre-edge table contents; there is no write bypass.
  assign w_fetch_bidx = IDX'(bidx_of(current_pc, IDX));
  assign w_fetch_tag  = TAGW'(tag_of(current_pc, IDX));
  assign w_ghr_ext    = IDX'(r_ghr);
  assign w_pred_idx   = (MODE == 1) ? (w_fetch_bidx ^ w_ghr_ext) : w_fetch_bidx;

  assign w_hit        = r_valid[w_fetch_bidx] && (r_tag[w_fetch_bidx] == w_fetch_tag);
  assign w_pred_taken = w_hit && (r_uncond[w_fetch_bidx] || r_pht[w_pred_idx][1]);
  assign w_pred_next  = w_pred_taken ? r_target[w_fetch_bidx] : current_pc + 32'd4;

  assign w_ctrl       = ID_EX_is_branch | ID_EX_is_jal | ID_EX_is_jalr;
  assign w_act_taken  = ID_EX_is_jal | ID_EX_is_jalr | (ID_EX_is_branch & EX_alu_bcond);
  assign w_act_target = ID_EX_is_jalr ? EX_alu_result : ID_EX_pc + ID_EX_imm;
  assign w_correct    = w_act_taken ? w_act_target : ID_EX_pc + 32'd4;
  assign w_flush      = w_ctrl && (IF_ID_pc != w_correct);

  assign w_ex_bidx    = IDX'(bidx_of(ID_EX_pc, IDX));
  assign w_ex_tag     = TAGW'(tag_of(ID_EX_pc, IDX));

  sat_counter2_update u_pht_upd (
    .cur   (r_pht[ID_EX_pred_idx]),
    .taken (w_act_taken),
    .nxt   (w_pht_next)
  );

  always_comb begin
    w_ghr_next    = r_ghr;
    w_ghr_next[0] = EX_alu_bcond;
    for (int i = 1; i < GHR_BITS; i++) begin
      w_ghr_next[i] = r_ghr[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_uncond[i] <= 1'b0;
        r_pht[i]    <= PHT_RESET;
      end
      r_ghr     <= '0;
      r_perf_br <= '0;
      r_perf_fl <= '0;
    end else if (w_ctrl) begin
      // Not-taken resolves never allocate, so cold entries stay invalid.
      if (w_act_taken) begin
        r_valid[w_ex_bidx]  <= 1'b1;
        r_tag[w_ex_bidx]    <= w_ex_tag;
        r_target[w_ex_bidx] <= w_act_target;
        r_uncond[w_ex_bidx] <= ID_EX_is_jal | ID_EX_is_jalr;
      end
      if (ID_EX_is_branch) begin
        r_pht[ID_EX_pred_idx] <= w_pht_next;
        if (MODE == 1) r_ghr <= w_ghr_next;
      end
      if (r_perf_br != 32'hFFFF_FFFF) r_perf_br <= r_perf_br + 32'd1;
      if (w_flush && (r_perf_fl != 32'hFFFF_FFFF)) r_perf_fl <= r_perf_fl + 32'd1;
    end
  end

  assign pred_idx      = w_pred_idx;
  assign next_pc       = w_flush ? w_correct : w_pred_next;
  assign is_flush      = w_flush;
  assign perf_branches = r_perf_br;
  assign perf_flushes  = r_perf_fl;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench: a bimodal and a gshare instance share stimulus and are
// checked against a table-level reference model of the predictor.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] current_pc = '0, IF_ID_pc = '0, ID_EX_pc = '0, ID_EX_imm = '0, EX_alu_result = '0;
  logic        ID_EX_is_branch = 1'b0, ID_EX_is_jal = 1'b0, ID_EX_is_jalr = 1'b0, EX_alu_bcond = 1'b0;
  logic [4:0]  pidx_in0 = '0, pidx_in1 = '0;
  logic [4:0]  pidx0, pidx1;
  logic [31:0] npc0, npc1, pb0, pb1, pf0, pf1;
  logic        fl0, fl1;

  always #5 clk = ~clk;

  branch_predictor_btb #(.ENTRIES(32), .GHR_BITS(5), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .current_pc(current_pc), .IF_ID_pc(IF_ID_pc),
    .ID_EX_pc(ID_EX_pc), .ID_EX_imm(ID_EX_imm), .EX_alu_result(EX_alu_result),
    .ID_EX_is_branch(ID_EX_is_branch), .ID_EX_is_jal(ID_EX_is_jal), .ID_EX_is_jalr(ID_EX_is_jalr),
    .EX_alu_bcond(EX_alu_bcond), .ID_EX_pred_idx(pidx_in0), .pred_idx(pidx0),
    .next_pc(npc0), .is_flush(fl0), .perf_branches(pb0), .perf_flushes(pf0));

  branch_predictor_btb #(.ENTRIES(32), .GHR_BITS(2), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .current_pc(current_pc), .IF_ID_pc(IF_ID_pc),
    .ID_EX_pc(ID_EX_pc), .ID_EX_imm(ID_EX_imm), .EX_alu_result(EX_alu_result),
    .ID_EX_is_branch(ID_EX_is_branch), .ID_EX_is_jal(ID_EX_is_jal), .ID_EX_is_jalr(ID_EX_is_jalr),
    .EX_alu_bcond(EX_alu_bcond), .ID_EX_pred_idx(pidx_in1), .pred_idx(pidx1),
    .next_pc(npc1), .is_flush(fl1), .perf_branches(pb1), .perf_flushes(pf1));

  // Reference model: per instance, a direct-mapped table of 32 slots holding the
  // owning PC's upper bits, its last taken target and a 0..3 direction score.
  bit          m_valid  [2][32];
  int unsigned m_tag    [2][32];
  logic [31:0] m_target [2][32];
  bit          m_uncond [2][32];
  int          m_pht    [2][32];
  int unsigned m_ghr    [2];
  logic [31:0] m_br     [2];
  logic [31:0] m_fl     [2];

  typedef struct packed {
    int              step;
    logic [1:0][31:0] npc;
    logic [1:0]       fl;
    logic [1:0][4:0]  idx;
    logic [1:0][31:0] pb;
    logic [1:0][31:0] pf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   step_no = 0;

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 32; j++) begin
        m_valid[i][j] = 0; m_tag[i][j] = 0; m_target[i][j] = '0;
        m_uncond[i][j] = 0; m_pht[i][j] = 1;
      end
      m_ghr[i] = 0; m_br[i] = '0; m_fl[i] = '0;
    end
  endfunction

  function automatic int unsigned m_slot(input logic [31:0] pc);
    return (pc / 4) % 32;
  endfunction

  function automatic int unsigned m_idx(input int i, input logic [31:0] pc);
    return (i == 1) ? (m_slot(pc) ^ m_ghr[1]) : m_slot(pc);
  endfunction

  function automatic logic [31:0] m_predict(input int i, input logic [31:0] pc);
    int unsigned s = m_slot(pc);
    bit hit = m_valid[i][s] && (m_tag[i][s] == pc / 128);
    if (hit && (m_uncond[i][s] || m_pht[i][m_idx(i, pc)] >= 2)) return m_target[i][s];
    return pc + 32'd4;
  endfunction

  // cls: 0 none, 1 conditional branch, 2 jal, 3 jalr
  function automatic logic [31:0] m_correct(input logic [31:0] expc, imm, alu, input int cls, input logic bc);
    bit taken = (cls >= 2) || (cls == 1 && bc);
    logic [31:0] tgt = (cls == 3) ? alu : expc + imm;
    return taken ? tgt : expc + 32'd4;
  endfunction

  function automatic void m_train(input int i, input logic [31:0] expc, imm, alu, input int cls,
                                  input logic bc, input logic [4:0] pi, input bit fl);
    bit taken;
    if (cls == 0) return;
    taken = (cls >= 2) || bc;
    if (taken) begin
      m_valid[i][m_slot(expc)]  = 1;
      m_tag[i][m_slot(expc)]    = expc / 128;
      m_target[i][m_slot(expc)] = (cls == 3) ? alu : expc + imm;
      m_uncond[i][m_slot(expc)] = (cls >= 2);
    end
    if (cls == 1) begin
      m_pht[i][pi] = taken ? ((m_pht[i][pi] < 3) ? m_pht[i][pi] + 1 : 3)
                           : ((m_pht[i][pi] > 0) ? m_pht[i][pi] - 1 : 0);
      if (i == 1) m_ghr[1] = ((m_ghr[1] << 1) | int'(bc)) & 3;
    end
    if (m_br[i] != 32'hFFFF_FFFF) m_br[i] = m_br[i] + 1;
    if (fl && m_fl[i] != 32'hFFFF_FFFF) m_fl[i] = m_fl[i] + 1;
  endfunction

  task automatic chk(input string name, input int stp, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, stp, act, expv);
    end
  endtask

  task automatic apply(input bit rst, input logic [31:0] cpc, ifid, expc, imm, alu,
                       input int cls, input logic bc, input logic [4:0] pi0, pi1);
    exp_t e;
    logic [31:0] corr;
    bit fl;
    @(posedge clk); #1;
    reset = rst;
    current_pc = cpc; IF_ID_pc = ifid; ID_EX_pc = expc; ID_EX_imm = imm; EX_alu_result = alu;
    ID_EX_is_branch = (cls == 1); ID_EX_is_jal = (cls == 2); ID_EX_is_jalr = (cls == 3);
    EX_alu_bcond = bc; pidx_in0 = pi0; pidx_in1 = pi1;
    if (rst) m_reset();
    corr = m_correct(expc, imm, alu, cls, bc);
    fl = (cls != 0) && (ifid != corr);
    step_no++;
    e.step = step_no;
    for (int i = 0; i < 2; i++) begin
      e.npc[i] = fl ? corr : m_predict(i, cpc);
      e.fl[i]  = fl;
      e.idx[i] = 5'(m_idx(i, cpc));
      e.pb[i]  = m_br[i];
      e.pf[i]  = m_fl[i];
    end
    q.push_back(e);
    if (!rst) begin
      m_train(0, expc, imm, alu, cls, bc, pi0, fl);
      m_train(1, expc, imm, alu, cls, bc, pi1, fl);
    end
    #1;
  endtask

  task automatic fetch(input bit rst, input logic [31:0] cpc);
    apply(rst, cpc, '0, '0, '0, '0, 0, 1'b0, 5'(m_idx(0, cpc)), 5'(m_idx(1, cpc)));
  endtask

  task automatic resolve(input logic [31:0] cpc, ifid, expc, imm, alu, input int cls, input logic bc);
    apply(1'b0, cpc, ifid, expc, imm, alu, cls, bc, 5'(m_idx(0, expc)), 5'(m_idx(1, expc)));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("next_pc0", e.step, npc0, e.npc[0]);
      chk("next_pc1", e.step, npc1, e.npc[1]);
      chk("is_flush0", e.step, 32'(fl0), 32'(e.fl[0]));
      chk("is_flush1", e.step, 32'(fl1), 32'(e.fl[1]));
      chk("pred_idx0", e.step, 32'(pidx0), 32'(e.idx[0]));
      chk("pred_idx1", e.step, 32'(pidx1), 32'(e.idx[1]));
      chk("perf_branches0", e.step, pb0, e.pb[0]);
      chk("perf_branches1", e.step, pb1, e.pb[1]);
      chk("perf_flushes0", e.step, pf0, e.pf[0]);
      chk("perf_flushes1", e.step, pf1, e.pf[1]);
    end
  end

  logic [31:0] pool [10] = '{32'h100, 32'h104, 32'h180, 32'h200, 32'h204,
                             32'h300, 32'h380, 32'h3A0, 32'hFFFF_FFFC, 32'h1000};
  logic [31:0] imms [4] = '{32'h40, 32'hFFFF_FF80, 32'h4, 32'h1C0};

  initial begin
    logic [31:0] pn1, pf_before, expc, imm, alu, ifid, corr;
    int cls;
    logic bc;
    m_reset();

    fetch(1'b1, 32'h100);
    chk("reset_next_pc", step_no, npc0, 32'h104);
    fetch(1'b0, 32'h100);
    chk("reset_pred_idx", step_no, 32'(pidx0), 32'h0);
    resolve(32'h108, 32'h104, 32'h100, 32'h40, '0, 1, 1'b1);
    chk("taken_flush_npc", step_no, npc0, 32'h140);
    fetch(1'b0, 32'h100);
    chk("taken_refetch_npc", step_no, npc0, 32'h140);
    chk("taken_perf_flushes", step_no, pf0, 32'h1);
    resolve(32'h144, 32'h140, 32'h100, 32'h40, '0, 1, 1'b0);
    chk("nt_flush_npc", step_no, npc0, 32'h104);
    fetch(1'b0, 32'h100);
    chk("nt_refetch_npc", step_no, npc0, 32'h104);
    resolve(32'h108, 32'h104, 32'h100, 32'h40, '0, 1, 1'b0);
    chk("nt_no_flush", step_no, 32'(fl0), 32'h0);
    resolve(32'h208, 32'h204, 32'h200, '0, 32'h380, 3, 1'b0);
    chk("jalr_flush_npc", step_no, npc0, 32'h380);
    fetch(1'b0, 32'h200);
    chk("jalr_refetch0", step_no, npc0, 32'h380);
    chk("jalr_refetch1", step_no, npc1, 32'h380);
    resolve(32'h384, 32'h380, 32'h200, '0, 32'h3A0, 3, 1'b0);
    chk("jalr_retarget_npc", step_no, npc0, 32'h3A0);
    fetch(1'b0, 32'h200);
    chk("jalr_new_target", step_no, npc0, 32'h3A0);
    resolve(32'h108, 32'h104, 32'h100, 32'h40, '0, 1, 1'b1);
    fetch(1'b0, 32'h180);
    chk("tag_alias_miss", step_no, npc0, 32'h184);
    fetch(1'b0, 32'hFFFF_FFFC);
    chk("pc_wrap", step_no, npc0, 32'h0);
    resolve(32'h0, 32'h4, 32'hFFFF_FFFC, 32'h4, '0, 2, 1'b0);
    chk("jal_wrap_target", step_no, npc0, 32'h0);

    // gshare warm-up on an alternating branch, fetch then resolve each instance
    fetch(1'b1, 32'h300);
    pf_before = '0;
    for (int k = 0; k < 8; k++) begin
      fetch(1'b0, 32'h300);
      pn1 = m_predict(1, 32'h300);
      apply(1'b0, pn1, pn1, 32'h300, 32'h40, '0, 1, (k % 2 == 0),
            5'(m_idx(0, 32'h300)), 5'(m_idx(1, 32'h300)));
      if (k == 4) pf_before = pf1;
    end
    fetch(1'b0, 32'h300);
    chk("gshare_warm_flushes", step_no, pf1 - pf_before, 32'h0);
    fetch(1'b1, 32'h300);
    fetch(1'b0, 32'h300);
    chk("midrun_reset_npc", step_no, npc1, 32'h304);
    chk("midrun_reset_ghr_idx", step_no, 32'(pidx1), 32'h0);

    for (int n = 0; n < 400; n++) begin
      cls  = ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(1, 3);
      bc   = 1'($urandom_range(0, 1));
      expc = pool[$urandom_range(0, 9)];
      imm  = imms[$urandom_range(0, 3)];
      alu  = pool[$urandom_range(0, 9)];
      corr = m_correct(expc, imm, alu, cls, bc);
      ifid = ($urandom_range(0, 1) == 1) ? corr : pool[$urandom_range(0, 9)];
      apply(($urandom_range(0, 99) == 0), pool[$urandom_range(0, 9)], ifid, expc, imm, alu,
            cls, bc, 5'(m_idx(0, expc)), 5'(m_idx(1, expc)));
    end
    fetch(1'b0, 32'h100);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised successor to the static not-taken next-PC/flush unit in the 5-stage RISC-V pipeline.
- Predicts next_pc in IF from a tagged branch target buffer (BTB) and a 2-bit pattern history table (PHT), with bimodal or gshare direction indexing.
- Resolves jal/jalr/branch in EX, raises is_flush on a wrong IF_ID_pc, and trains the tables at the clock edge.
- Keeps saturating mispredict/branch performance counters.

Parameters:
- ENTRIES, 32, BTB and PHT depth; power of two, 4..1024; IDX = log2(ENTRIES).
- GHR_BITS, 5, global history length; 1..IDX.
- MODE, 0, direction indexing: 0 = bimodal (PC only), 1 = gshare (PC XOR GHR).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- current_pc  in  32  PC being fetched this cycle.
- IF_ID_pc  in  32  PC of the instruction currently in ID.
- ID_EX_pc  in  32  PC of the instruction in EX.
- ID_EX_imm  in  32  immediate of the EX instruction.
- EX_alu_result  in  32  jalr target computed in EX.
- ID_EX_is_branch, ID_EX_is_jal, ID_EX_is_jalr  in  1 each  EX instruction class; at most one is high.
- EX_alu_bcond  in  1  branch condition outcome.
- ID_EX_pred_idx  in  IDX  PHT index captured at fetch and carried down the pipeline.
- pred_idx  out  IDX  PHT index used for current_pc; the pipeline latches it through IF/ID and ID/EX.
- next_pc  out  32  PC to fetch next cycle.
- is_flush  out  1  squash the IF/ID and ID/EX-bound instructions.
- perf_branches  out  32  resolved control-flow instruction count.
- perf_flushes  out  32  flush count.

Behaviour:
- Indexing:
  - bidx(pc) = pc[IDX+1:2]; tag(pc) = pc[31:IDX+2].
  - pred_idx = bidx(current_pc) in MODE 0; bidx(current_pc) XOR zero-extended GHR in MODE 1.
- Predict (combinational, current_pc):
  - hit = valid[bidx] && tag match.
  - pred_taken = hit && (uncond[bidx] || pht[pred_idx][1]).
  - pred_next = pred_taken ? target[bidx] : current_pc+4.
- Resolve (combinational, EX stage):
  - ctrl = is_branch | is_jal | is_jalr.
  - act_taken = is_jal | is_jalr | (is_branch & bcond).
  - act_target = is_jalr ? EX_alu_result : ID_EX_pc+ID_EX_imm.
  - correct = act_taken ? act_target : ID_EX_pc+4.
  - is_flush = ctrl && (IF_ID_pc != correct).
- Output select: next_pc = is_flush ? correct : pred_next. A flush always overrides the prediction.
- Update (posedge clk, only when ctrl):
  - If act_taken: valid[bidx(ID_EX_pc)]=1, tag and target=act_target written, uncond = is_jal|is_jalr.
  - If not taken: BTB entry left unchanged (no allocation on not-taken).
  - If is_branch: pht[ID_EX_pred_idx] saturating +1 when taken, -1 when not; clamp at 2'b00 and 2'b11.
  - If is_branch and MODE 1: GHR = {GHR[GHR_BITS-2:0], bcond}. jal/jalr do not shift the GHR.
  - perf_branches +1; perf_flushes +1 when is_flush. Both saturate at 32'hFFFF_FFFF.
- Same-cycle read/write to one entry: prediction uses the pre-edge contents; no bypass.
- The pipeline guarantees each instruction occupies ID/EX for exactly one cycle (stalls insert bubbles with all is_* low). There is no double training.
- Reset:
  - valid=0, targets=0, uncond=0, pht=2'b01 (weakly not-taken), GHR=0, perf counters=0.
  - Outputs then follow combinationally: next_pc=current_pc+4; is_flush=0 unless ctrl is high.
  - Reset mid-operation discards all training immediately (asynchronous).
- Arithmetic: all PC sums are 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0.

Decomposition:
- Shared package bp_pkg holds:
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - PHT_RESET=WNT.
  - Index/tag slicing helper functions.
- One sub-module, sat_counter2_update: pure 2-bit saturating next-state function with inputs cur and taken.
- BTB and PHT arrays stay in the top level.

Test Plan:
- Reset, then current_pc=0x100, no ctrl in EX -> next_pc=0x104, is_flush=0, pred_idx=bidx(0x100), perf counters 0.
- Taken branch: ID_EX_pc=0x100, imm=0x40, bcond=1, IF_ID_pc=0x104 -> is_flush=1, next_pc=0x140, perf_flushes=1. Then fetch 0x100 -> hit; counter at WNT+1=WT so pred_taken=1; next_pc=0x140.
- Same branch resolved not-taken twice with IF_ID_pc=0x140 -> first flush with next_pc=0x104, counter falls to WNT. Next fetch of 0x100 predicts 0x104 and a not-taken resolve produces no flush.
- jalr: ID_EX_pc=0x200, EX_alu_result=0x380, IF_ID_pc=0x204 -> flush, next_pc=0x380. Refetch 0x200 -> next_pc=0x380 (uncond). Later resolve to 0x3A0 with IF_ID_pc=0x380 -> flush, target rewritten to 0x3A0.
- Tag alias (ENTRIES=32): train 0x100 taken, then fetch 0x180 (same bidx, different tag) -> no hit, next_pc=0x184.
- MODE=1, GHR_BITS=2: alternating T/NT branch at 0x300 for 8 resolves -> after warm-up, no flushes for the last 4. Assert reset mid-run -> GHR=0 and all predictions revert to pc+4.
